// File: rtl/taus_pkg.sv
// taus_pkg: shared constants, seed helpers and FSM state type for the
// multi-channel Tausworthe generator.
`default_nettype none

package taus_pkg;

  localparam logic [31:0] MIN0  = 32'd2;
  localparam logic [31:0] MIN1  = 32'd8;
  localparam logic [31:0] MIN2  = 32'd16;

  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  localparam logic [31:0] DFLT_SEED0 = 32'hFFFF_FFFF;
  localparam logic [31:0] DFLT_SEED1 = 32'hCCCC_CCCC;
  localparam logic [31:0] DFLT_SEED2 = 32'h00FF_00FF;
  localparam logic [31:0] GOLDEN     = 32'h9E37_79B9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Seeds below a component's minimum would lock that component at zero.
  function automatic logic [31:0] legalise(input logic [1:0] k, input logic [31:0] v);
    logic [31:0] m;
    case (k)
      2'd0:    m = MIN0;
      2'd1:    m = MIN1;
      default: m = MIN2;
    endcase
    return (v < m) ? v + m : v;
  endfunction

  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned c,
                                            input logic [1:0] k);
    logic [31:0] cc;
    cc = c;
    return legalise(k, base ^ (cc * GOLDEN));
  endfunction

endpackage

`default_nettype wire

// File: rtl/taus_core.sv
// taus_core: one Tausworthe channel -- three state words, loadable
// per component, advanced one step when i_step is high.
`default_nettype none

module taus_core
  import taus_pkg::*;
#(
  parameter logic [31:0] RST_S0 = DFLT_SEED0,
  parameter logic [31:0] RST_S1 = DFLT_SEED1,
  parameter logic [31:0] RST_S2 = DFLT_SEED2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [1:0]  i_load_sel,
  input  logic [31:0] i_load_data,
  input  logic        i_step,
  output logic [31:0] o_rand
);

  logic [31:0] r_s0, r_s1, r_s2;
  logic [31:0] w_n0, w_n1, w_n2;
  logic [31:0] w_legal;

  assign w_n0    = ((r_s0 & MASK0) << 12) ^ (((r_s0 << 13) ^ r_s0) >> 19);
  assign w_n1    = ((r_s1 & MASK1) << 4)  ^ (((r_s1 << 2)  ^ r_s1) >> 25);
  assign w_n2    = ((r_s2 & MASK2) << 17) ^ (((r_s2 << 3)  ^ r_s2) >> 11);
  assign w_legal = legalise(i_load_sel, i_load_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= RST_S0;
      r_s1 <= RST_S1;
      r_s2 <= RST_S2;
    end else if (i_load) begin
      case (i_load_sel)
        2'd0:    r_s0 <= w_legal;
        2'd1:    r_s1 <= w_legal;
        2'd2:    r_s2 <= w_legal;
        default: ;
      endcase
    end else if (i_step) begin
      r_s0 <= w_n0;
      r_s1 <= w_n1;
      r_s2 <= w_n2;
    end
  end

  assign o_rand = r_s0 ^ r_s1 ^ r_s2;

endmodule

`default_nettype wire

// File: rtl/taus_gen_multi.sv
// taus_gen_multi: NCH parallel Tausworthe generators sharing one
// IDLE/WARM/RUN controller with warm-up, valid/ready output and count.
`default_nettype none

module taus_gen_multi
  import taus_pkg::*;
#(
  parameter int          NCH       = 2,
  parameter int          WARMUP    = 8,
  parameter logic [31:0] DEF_SEED0 = DFLT_SEED0,
  parameter logic [31:0] DEF_SEED1 = DFLT_SEED1,
  parameter logic [31:0] DEF_SEED2 = DFLT_SEED2,
  parameter int          CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_wr,
  input  logic [CHW-1:0]    seed_ch,
  input  logic [1:0]        seed_sel,
  input  logic [31:0]       seed_data,
  input  logic              start,
  input  logic              stop,
  output logic [NCH*32-1:0] rand_data,
  output logic              rand_valid,
  input  logic              rand_ready,
  output logic              busy,
  output logic [31:0]       count
);

  localparam logic [7:0]   WARM_LAST = 8'(WARMUP - 1);
  localparam logic [CHW:0] NCH_W     = (CHW + 1)'(NCH);

  state_t      r_state;
  logic [7:0]  r_warm_cnt;
  logic [31:0] r_count;
  logic        r_valid;
  logic        r_busy;

  logic        w_step;
  logic        w_load;

  assign w_step = (r_state == ST_WARM) || (r_valid && rand_ready);
  assign w_load = (r_state == ST_IDLE) && seed_wr && (seed_sel != 2'd3) &&
                  ({1'b0, seed_ch} < NCH_W);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    taus_core #(
      .RST_S0(chan_seed(DEF_SEED0, c, 2'd0)),
      .RST_S1(chan_seed(DEF_SEED1, c, 2'd1)),
      .RST_S2(chan_seed(DEF_SEED2, c, 2'd2))
    ) u_core (
      .clk        (clk),
      .rst        (reset),
      .i_load     (w_load && (seed_ch == CHW'(c))),
      .i_load_sel (seed_sel),
      .i_load_data(seed_data),
      .i_step     (w_step),
      .o_rand     (rand_data[32*c +: 32])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_warm_cnt <= 8'd0;
      r_count    <= 32'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_count    <= 32'd0;
            r_warm_cnt <= 8'd0;
            if (WARMUP == 0) begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_WARM;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_WARM: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_warm_cnt == WARM_LAST) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_warm_cnt <= r_warm_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          // A handshake coincident with stop still completes.
          if (rand_ready) r_count <= r_count + 32'd1;
          if (stop) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rand_valid = r_valid;
  assign busy       = r_busy;
  assign count      = r_count;

endmodule

`default_nettype wire
